// File: rtl/data_aligner.sv
// Byte-addressed load/store to word-granular memory port adapter; splits word-straddling accesses into two beats.
// Optional trap on straddling accesses instead of splitting: define DATA_ALIGNER_TRAP_EN.
module data_aligner #(
  parameter int N = 32,
  parameter int V = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N-1:0]     req_addr,
  input  logic             req_vec,
  input  logic             req_read,
  input  logic             req_write,
  input  logic [V-1:0]     req_wdata,
  output logic [N-1:0]     mem_address,
  output logic [V/8-1:0]   mem_byteena,
  output logic [V-1:0]     mem_write_data,
  output logic             mem_rden,
  output logic             mem_wren,
  input  logic [V-1:0]     mem_read_data,
  output logic             done,
  output logic [V-1:0]     load_data,
  output logic             misaligned_err
);

  localparam int B  = V / 8;
  localparam int OW = $clog2(B);
  localparam int WW = 14;

`ifdef DATA_ALIGNER_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE0  = 3'd1;
  localparam logic [2:0] S_ISSUE1  = 3'd2;
  localparam logic [2:0] S_WAIT_RD = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]     state;
  logic [2:0]     state_next;
  logic [WW-1:0]  word_q;
  logic [OW-1:0]  off_q;
  logic           vec_q;
  logic           write_q;
  logic           split_q;
  logic [2*B-1:0] mask_q;
  logic [2*V-1:0] data_q;
  logic [V-1:0]   beat0_q;

  logic [OW-1:0]  req_off;
  logic [WW-1:0]  req_word;
  logic [B-1:0]   size_mask;
  logic [2*B-1:0] req_mask;
  logic [V-1:0]   wdata_sized;
  logic [2*V-1:0] req_data;
  logic           req_split;
  logic           accept;
  logic [WW-1:0]  word_next;
  logic [2*V-1:0] merged;
  logic [2*V-1:0] shifted;
  logic [V-1:0]   load_next;
  logic           unused_ok;

  // Place the access in a two-word window so the straddling part lands in the upper word.
  assign req_off     = req_addr[OW-1:0];
  assign req_word    = req_addr[OW+WW-1:OW];
  assign size_mask   = req_vec ? {B{1'b1}} : {{(B-4){1'b0}}, 4'hF};
  assign req_mask    = {{B{1'b0}}, size_mask} << req_off;
  assign wdata_sized = req_vec ? req_wdata : {{(V-32){1'b0}}, req_wdata[31:0]};
  assign req_data    = {{V{1'b0}}, wdata_sized} << {req_off, 3'b000};
  assign req_split   = |req_mask[2*B-1:B];

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready && (req_read || req_write);
  assign word_next = word_q + {{(WW-1){1'b0}}, 1'b1};

  // The last read beat arrives during WAIT_RD; the lower word of a split was captured in ISSUE1.
  assign merged    = split_q ? {mem_read_data, beat0_q} : {{V{1'b0}}, mem_read_data};
  assign shifted   = merged >> {off_q, 3'b000};
  assign load_next = vec_q ? shifted[V-1:0] : {{(V-32){1'b0}}, shifted[31:0]};

  assign unused_ok = &{1'b0, shifted[2*V-1:V], req_addr[N-1:OW+WW]};

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (accept) state_next = (TRAP_EN && req_split) ? S_DONE : S_ISSUE0;
      S_ISSUE0:  state_next = split_q ? S_ISSUE1 : (write_q ? S_DONE : S_WAIT_RD);
      S_ISSUE1:  state_next = write_q ? S_DONE : S_WAIT_RD;
      S_WAIT_RD: state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_address    = '0;
    mem_byteena    = '0;
    mem_write_data = '0;
    mem_rden       = 1'b0;
    mem_wren       = 1'b0;
    case (state)
      S_ISSUE0: begin
        mem_address    = {{(N-WW){1'b0}}, word_q};
        mem_byteena    = mask_q[B-1:0];
        mem_write_data = write_q ? data_q[V-1:0] : '0;
        mem_rden       = !write_q;
        mem_wren       = write_q;
      end
      S_ISSUE1: begin
        mem_address    = {{(N-WW){1'b0}}, word_next};
        mem_byteena    = mask_q[2*B-1:B];
        mem_write_data = write_q ? data_q[2*V-1:V] : '0;
        mem_rden       = !write_q;
        mem_wren       = write_q;
      end
      default: ;
    endcase
  end

  assign done = (state == S_DONE);

`ifdef DATA_ALIGNER_TRAP_EN
  assign misaligned_err = (state == S_DONE) && split_q;
`else
  assign misaligned_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      word_q    <= '0;
      off_q     <= '0;
      vec_q     <= 1'b0;
      write_q   <= 1'b0;
      split_q   <= 1'b0;
      mask_q    <= '0;
      data_q    <= '0;
      beat0_q   <= '0;
      load_data <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        word_q  <= req_word;
        off_q   <= req_off;
        vec_q   <= req_vec;
        write_q <= req_write;
        split_q <= req_split;
        mask_q  <= req_mask;
        data_q  <= req_data;
      end
      if (state == S_ISSUE1) beat0_q <= mem_read_data;
      if (state == S_WAIT_RD) load_data <= load_next;
    end
  end

endmodule

// File: tb/tb_data_aligner.sv
// Directed bench for data_aligner: byte-level reference memory plus a per-cycle expected-output trace.
module tb_data_aligner;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [31:0]  req_addr = '0;
  logic         req_vec = 1'b0;
  logic         req_read = 1'b0;
  logic         req_write = 1'b0;
  logic [255:0] req_wdata = '0;
  logic [31:0]  mem_address;
  logic [31:0]  mem_byteena;
  logic [255:0] mem_write_data;
  logic         mem_rden;
  logic         mem_wren;
  logic [255:0] mem_read_data;
  logic         done;
  logic [255:0] load_data;
  logic         misaligned_err;

  data_aligner dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_vec(req_vec), .req_read(req_read), .req_write(req_write), .req_wdata(req_wdata),
    .mem_address(mem_address), .mem_byteena(mem_byteena), .mem_write_data(mem_write_data),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_read_data(mem_read_data),
    .done(done), .load_data(load_data), .misaligned_err(misaligned_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         ready;
    logic         rden;
    logic         wren;
    logic [31:0]  addr;
    logic [31:0]  be;
    logic [255:0] wd;
    logic         done;
    logic [255:0] ld;
    logic         err;
  } exp_t;

  exp_t         exp_q[$];
  logic [7:0]   ref_bytes [524288];
  logic [255:0] mem [16384];
  logic [255:0] model_load = '0;
  logic [255:0] cur_load = '0;
  int           n_vec = 0;
  int           n_miss = 0;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  // Word-wide memory seen by the DUT; read data appears one cycle after rden.
  always @(posedge clk) begin
    logic [255:0] t;
    if (mem_wren) begin
      t = mem[mem_address[13:0]];
      for (int l = 0; l < 32; l++)
        if (mem_byteena[l]) t[l*8 +: 8] = mem_write_data[l*8 +: 8];
      mem[mem_address[13:0]] = t;
    end
    if (mem_rden) mem_read_data <= mem[mem_address[13:0]];
  end

  // Byte-at-a-time placement of an access into the word at addr and the word after it.
  task automatic computeBeats(input logic [31:0] addr, input logic vec, input logic [255:0] wdata,
                              output logic [13:0] w0, output logic [13:0] w1,
                              output logic [31:0] be0, output logic [31:0] be1,
                              output logic [255:0] d0, output logic [255:0] d1, output logic split);
    int o, s, p;
    o = int'(addr[4:0]);
    s = vec ? 32 : 4;
    w0 = addr[18:5];
    w1 = w0 + 14'd1;
    be0 = '0; be1 = '0; d0 = '0; d1 = '0;
    for (int k = 0; k < s; k++) begin
      p = o + k;
      if (p < 32) begin
        be0[p] = 1'b1;
        d0[p*8 +: 8] = wdata[k*8 +: 8];
      end else begin
        be1[p-32] = 1'b1;
        d1[(p-32)*8 +: 8] = wdata[k*8 +: 8];
      end
    end
    split = (o + s > 32);
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic vec, input logic rd,
                               input logic wr, input logic [255:0] wdata);
    logic [13:0]  w0, w1;
    logic [31:0]  be0, be1;
    logic [255:0] d0, d1, ld;
    logic [18:0]  a;
    logic         split;
    exp_t         e;
    int           n, s;
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_vec = vec;
    req_read = rd; req_write = wr; req_wdata = wdata;
    computeBeats(addr, vec, wdata, w0, w1, be0, be1, d0, d1, split);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    n = 0;
    if (rd || wr) begin
      e = '0; e.rden = !wr; e.wren = wr; e.addr = {18'b0, w0}; e.be = be0;
      e.wd = wr ? d0 : '0; e.ld = model_load;
      exp_q.push_back(e); n++;
      if (split) begin
        e.addr = {18'b0, w1}; e.be = be1; e.wd = wr ? d1 : '0;
        exp_q.push_back(e); n++;
      end
      if (!wr) begin
        e = '0; e.ld = model_load;
        exp_q.push_back(e); n++;
      end
      s = vec ? 32 : 4;
      ld = '0;
      for (int k = 0; k < s; k++) begin
        a = addr[18:0] + 19'(k);
        if (wr) ref_bytes[a] = wdata[k*8 +: 8];
        else ld[k*8 +: 8] = ref_bytes[a];
      end
      if (!wr) model_load = ld;
      e = '0; e.done = 1'b1; e.ld = model_load;
      exp_q.push_back(e); n++;
    end
    repeat (n + 1) @(negedge clk);
  endtask

  // Compare process: one expected entry per cycle while a request is in flight, idle otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      cur_load = '0;
      exp_q.delete();
    end
    if (!rst && exp_q.size() > 0) e = exp_q.pop_front();
    else begin
      e = '0; e.ready = 1'b1; e.ld = cur_load;
    end
    if (e.done) cur_load = e.ld;
    checkOutput("req_ready", {255'b0, req_ready}, {255'b0, e.ready});
    checkOutput("mem_rden", {255'b0, mem_rden}, {255'b0, e.rden});
    checkOutput("mem_wren", {255'b0, mem_wren}, {255'b0, e.wren});
    if (e.rden || e.wren) checkOutput("mem_address", {224'b0, mem_address}, {224'b0, e.addr});
    checkOutput("mem_byteena", {224'b0, mem_byteena}, {224'b0, e.be});
    checkOutput("mem_write_data", mem_write_data, e.wd);
    checkOutput("done", {255'b0, done}, {255'b0, e.done});
    checkOutput("load_data", load_data, e.ld);
    checkOutput("misaligned_err", {255'b0, misaligned_err}, {255'b0, e.err});
  end

  initial begin
    logic [255:0] ramp, pat, pat2, junk;
    logic [13:0]  w0, w1;
    logic [31:0]  be0, be1;
    logic [255:0] d0, d1;
    logic         split;
    exp_t         e;
    for (int i = 0; i < 524288; i++) ref_bytes[i] = 8'h00;
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    for (int i = 0; i < 32; i++) begin
      ramp[i*8 +: 8] = 8'(i);
      pat[i*8 +: 8]  = 8'(i * 7 + 8'h30);
      pat2[i*8 +: 8] = 8'(8'hF0 - i * 3);
    end
    junk = {224'hDEADBEEF_0BADF00D_CAFEF00D_12345678_9ABCDEF0_55AA55AA_A5A5A5A5, 32'hAABBCCDD};
    #1 rst = 1'b1;
    #22 rst = 1'b0;

    // Hand-computed placements pin the byte-level model itself.
    computeBeats(32'h45, 1'b1, pat, w0, w1, be0, be1, d0, d1, split);
    checkOutput("pin_45_be0", {224'b0, be0}, 256'hFFFFFFE0);
    checkOutput("pin_45_be1", {224'b0, be1}, 256'h0000001F);
    computeBeats(32'h7E, 1'b0, junk, w0, w1, be0, be1, d0, d1, split);
    checkOutput("pin_7e_be0", {224'b0, be0}, 256'hC0000000);
    checkOutput("pin_7e_be1", {224'b0, be1}, 256'h00000003);
    checkOutput("pin_7e_d0", {240'b0, d0[255:240]}, 256'hCCDD);
    checkOutput("pin_7e_d1", d1, 256'hAABB);
    computeBeats(32'h7FFE1, 1'b1, pat2, w0, w1, be0, be1, d0, d1, split);
    checkOutput("pin_wrap_w", {228'b0, w0, w1}, {228'b0, 14'd16383, 14'd0});
    checkOutput("pin_wrap_be", {192'b0, be0, be1}, {192'b0, 32'hFFFFFFFE, 32'h00000001});

    applyStimulus(32'h40, 1'b1, 1'b0, 1'b1, ramp);
    applyStimulus(32'h40, 1'b1, 1'b1, 1'b0, '0);
    checkOutput("t2_load_ramp", load_data, ramp);
    applyStimulus(32'h45, 1'b1, 1'b0, 1'b1, pat);
    applyStimulus(32'h45, 1'b1, 1'b1, 1'b0, '0);
    checkOutput("t3_load_pat", load_data, pat);
    applyStimulus(32'h7E, 1'b0, 1'b0, 1'b1, junk);
    applyStimulus(32'h7E, 1'b0, 1'b1, 1'b0, '0);
    checkOutput("t4_load_scalar", load_data, 256'hAABBCCDD);
    applyStimulus(32'h7FFE1, 1'b1, 1'b0, 1'b1, pat2);
    applyStimulus(32'h7FFE1, 1'b1, 1'b1, 1'b0, '0);
    checkOutput("t5_load_wrap", load_data, pat2);
    applyStimulus(32'h100, 1'b0, 1'b0, 1'b0, junk);
    applyStimulus(32'h102, 1'b0, 1'b1, 1'b1, 256'h11223344);
    applyStimulus(32'h100, 1'b0, 1'b1, 1'b0, '0);
    checkOutput("rw_as_write", load_data, 256'h33440000);
    applyStimulus(32'h41, 1'b0, 1'b1, 1'b0, '0);

    // Split read aborted by reset while the second beat is on the port.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h45; req_vec = 1'b1; req_read = 1'b1; req_write = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_read = 1'b0;
    e = '0; e.rden = 1'b1; e.addr = 32'd2; e.be = 32'hFFFFFFE0; e.ld = model_load;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    checkOutput("abort_rden_issue1", {255'b0, mem_rden}, 256'h1);
    checkOutput("abort_addr_issue1", {224'b0, mem_address}, 256'h3);
    rst = 1'b1;
    #1;
    checkOutput("abort_rden_drop", {255'b0, mem_rden}, 256'h0);
    checkOutput("abort_ready", {255'b0, req_ready}, 256'h1);
    checkOutput("abort_done", {255'b0, done}, 256'h0);
    checkOutput("abort_load_clr", load_data, 256'h0);
    model_load = '0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    applyStimulus(32'h40, 1'b1, 1'b1, 1'b0, '0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/data_aligner.md
Name: data_aligner

Overview:
Sits directly upstream of the memory block and drives its data-side port: MemAddress, Byteena, MemWriteData, Rden and Wren. It also consumes MemReadData.
It converts a byte-addressed pipeline load/store into one or two word-granular memory transactions. The access is a 32-bit scalar or a V-bit vector.
Misaligned accesses that straddle a V-bit memory word are split into two beats. Read beats are merged and realigned into a single result.

Parameters:
N, 32, address / scalar width
V, 256, memory word (vector) width; B = V/8 = 32 bytes per word, offset width OW = log2(B) = 5

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request strobe from pipeline
req_ready  out  1  high when a request can be accepted
req_addr  in  N  byte address
req_vec  in  1  1 = V-bit vector access, 0 = 32-bit scalar
req_read  in  1  load
req_write  in  1  store
req_wdata  in  V  store data; scalar uses [31:0]
mem_address  out  N  word address to memory
mem_byteena  out  B  byte enables to memory
mem_write_data  out  V  write data to memory
mem_rden  out  1  read enable to memory
mem_wren  out  1  write enable to memory
mem_read_data  in  V  memory read data, valid 1 cycle after rden
done  out  1  one-cycle completion pulse
load_data  out  V  aligned load result
misaligned_err  out  1  trap flag (see Optional Feature)

Behaviour:
- Reset (async): state IDLE. All outputs 0 except req_ready = 1. Any in-flight beat is aborted immediately and done never fires for it.
- Decoding the request address:
  - o = req_addr[OW-1:0]
  - w = req_addr[OW+13:OW], 14 bits
  - S = 32 if req_vec else 4
- Mask and data construction, in 2B-bit / 2V-bit space:
  - M = ((1<<S)-1) << o
  - D = req_wdata(size-masked) << 8*o
  - beat0: byteena M[B-1:0], data D[V-1:0], address w
  - beat1: byteena M[2B-1:B], data D[2V-1:V], address (w+1) mod 2^14 (16383 wraps to 0)
  - split = |M[2B-1:B]
- mem_address is the word index zero-extended to N.
- Request is latched on req_valid && req_ready. req_ready = (state==IDLE).
- req_read && req_write both set: treated as write.
- Neither set: request ignored; no state change.
- FSM states: IDLE, ISSUE0, ISSUE1, WAIT_RD, DONE.
  - IDLE -> ISSUE0 on accept.
  - ISSUE0: drive beat0; rden or wren = 1. Next state is ISSUE1 if split, else WAIT_RD (read) or DONE (write).
  - ISSUE1: drive beat1 and capture beat0 read data. Next state is WAIT_RD (read) or DONE (write).
  - WAIT_RD: capture the last read beat -> DONE.
  - DONE: done = 1. For a read, load_data = ({beat1,beat0} >> 8*o) masked to S bytes, scalar zero-extended. -> IDLE.
- Latency, with T = accept edge (done high during the cycle shown):
  - write: T+2, or T+3 if split
  - read: T+3, or T+4 if split
- mem_rden / mem_wren are high for exactly one cycle per beat. When they are low, byteena and data are 0.
- load_data holds until the next read completion. Writes leave it unchanged.

Optional Feature:
Macro DATA_ALIGNER_TRAP_EN.
- Defined:
  - A request with split = 1 issues no memory beat.
  - The FSM goes IDLE -> DONE, with done = 1 and misaligned_err = 1 at T+1.
  - load_data is unchanged.
- Undefined:
  - Split handling as above.
  - misaligned_err is tied 0.

Test Plan:
1. Vector write addr 0x40, data ramp 0x1F..0x00 -> single beat, addr 2, byteena 0xFFFFFFFF, wren 1 cycle; done at T+2.
2. Vector read addr 0x40 after (1) -> rden 1 cycle at addr 2; done at T+3; load_data == ramp.
3. Vector write then read at addr 0x45 ->
   - beats: addr 2 byteena 0xFFFFFFE0, then addr 3 byteena 0x0000001F
   - write done at T+3, read done at T+4; load_data equals the written data.
4. Scalar write addr 0x7E, data 0xAABBCCDD ->
   - beat0: addr 3, byteena 0xC0000000, bytes 30 = DD, 31 = CC
   - beat1: addr 4, byteena 0x00000003, bytes 0 = BB, 1 = AA
   - scalar read back -> load_data = 0x...00AABBCCDD
5. Vector write addr 0x7FFE1 -> beat0 addr 16383 byteena 0xFFFFFFFE; beat1 addr 0 byteena 0x00000001.
6. Split read, rst pulsed during ISSUE1 -> rden drops immediately, done never pulses, req_ready = 1 after release. With DATA_ALIGNER_TRAP_EN, the request from (3) gives done = 1 and misaligned_err = 1 at T+1 with no rden/wren.
